rv32_id_ex_stage: RTL and testbench

// - ID->EX pipeline stage of the 5-stage RV32 core; sits directly upstream of the EX-stage barrel shifter and ALU.
// - Registers decoded operands and resolves EX/MEM and MEM/WB forwarding for rs1/rs2.
// - Detects load-use hazards and inserts one bubble; honours flush and downstream backpressure.
// - Decodes the shift-control bits (enable/logical/direction/immediate) so EX sees them registered, not decoded in EX.

---
 rtl/rv32_pkg.sv | 33 +++
 rtl/rv32_fwd_mux.sv | 24 ++
 rtl/rv32_id_ex_stage.sv | 121 ++++++++++++
 tb/tb_rv32_id_ex_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: opcodes, shift funct3 codes and the ID->EX pipeline payload.
package rv32_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef struct packed {
    logic              valid;
    logic [31:0]       instr;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [REG_AW-1:0] rd;
    logic              wr_en;
    logic              is_load;
    logic              shift_en;
    logic              shift_logical;
    logic              shift_direction;
    logic              shift_immediate;
  } id_ex_t;
endpackage

// File: rtl/rv32_fwd_mux.sv
// Per-source operand select: EX/MEM result beats MEM/WB result beats the register file.
module rv32_fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              exm_wr_en,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              mwb_wr_en,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_data,
  output logic [XLEN-1:0]   rs_data
);
  logic rs_nz;

  always_comb begin
    rs_nz   = (rs_addr != '0);
    rs_data = rf_data;
    if (rs_nz && exm_wr_en && (exm_rd == rs_addr))      rs_data = exm_data;
    else if (rs_nz && mwb_wr_en && (mwb_rd == rs_addr)) rs_data = mwb_data;
  end
endmodule

// File: rtl/rv32_id_ex_stage.sv
// ID->EX pipeline register with operand forwarding, load-use stall and registered shifter controls.
module rv32_id_ex_stage
  import rv32_pkg::*;
#(
  parameter int XLEN   = rv32_pkg::XLEN,
  parameter int REG_AW = rv32_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [31:0]       id_instr,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic              exm_wr_en,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              mwb_wr_en,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_data,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [31:0]       ex_code_bus,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1,
  output logic [XLEN-1:0]   ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_wr_en,
  output logic              ex_is_load,
  output logic              ex_shift_en,
  output logic              ex_shift_logical,
  output logic              ex_shift_direction,
  output logic              ex_shift_immediate
);
  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [REG_AW-1:0] rs1_a, rs2_a, rd_a;
  logic [XLEN-1:0]   rs1_fwd, rs2_fwd;
  logic              rs1_used, rs2_used, hazard, accept, shift_ok;
  id_ex_t            id_pkt, ex_d, ex_q;

  assign opc   = id_instr[6:0];
  assign f3    = id_instr[14:12];
  assign rd_a  = id_instr[11:7];
  assign rs1_a = id_instr[19:15];
  assign rs2_a = id_instr[24:20];

  rv32_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr(rs1_a), .rf_data(id_rs1_data),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .rs_data(rs1_fwd)
  );

  rv32_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr(rs2_a), .rf_data(id_rs2_data),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .rs_data(rs2_fwd)
  );

  // A stall only matters for sources the instruction format actually reads.
  always_comb begin
    rs1_used = !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    rs2_used = opc inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    hazard   = ex_q.valid && ex_q.is_load && ex_q.wr_en && (ex_q.rd != '0) &&
               ((rs1_used && (ex_q.rd == rs1_a)) || (rs2_used && (ex_q.rd == rs2_a)));
  end

  assign id_ready = ex_ready && !hazard && !flush;
  assign accept   = id_valid && id_ready;

  always_comb begin
    id_pkt         = '0;
    id_pkt.valid   = 1'b1;
    id_pkt.instr   = id_instr;
    id_pkt.pc      = id_pc;
    id_pkt.rs1     = rs1_fwd;
    id_pkt.rs2     = rs2_fwd;
    id_pkt.rd      = rd_a;
    id_pkt.wr_en   = (opc inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR}) &&
                     (rd_a != '0);
    id_pkt.is_load = (opc == OPC_LOAD);
    // SLLI with non-zero upper immediate bits is malformed; let it through as a non-shift.
    shift_ok = ((opc == OPC_OP) || ((opc == OPC_OP_IMM) && !((f3 == F3_SLL) && (id_instr[31:25] != '0)))) &&
               ((f3 == F3_SLL) || (f3 == F3_SR));
    if (shift_ok) begin
      id_pkt.shift_en        = 1'b1;
      id_pkt.shift_direction = f3[2];
      id_pkt.shift_logical   = !id_instr[30];
      id_pkt.shift_immediate = (opc == OPC_OP_IMM);
    end
  end

  // Bubbles are all-zero so no stale rd/load flag can trigger a false hazard.
  always_comb begin
    ex_d = ex_q;
    if (flush)         ex_d = '0;
    else if (ex_ready) ex_d = accept ? id_pkt : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign ex_valid           = ex_q.valid;
  assign ex_code_bus        = ex_q.instr;
  assign ex_pc              = ex_q.pc;
  assign ex_rs1             = ex_q.rs1;
  assign ex_rs2             = ex_q.rs2;
  assign ex_rd              = ex_q.rd;
  assign ex_wr_en           = ex_q.wr_en;
  assign ex_is_load         = ex_q.is_load;
  assign ex_shift_en        = ex_q.shift_en;
  assign ex_shift_logical   = ex_q.shift_logical;
  assign ex_shift_direction = ex_q.shift_direction;
  assign ex_shift_immediate = ex_q.shift_immediate;
endmodule

// File: tb/tb_rv32_id_ex_stage.sv
// Directed bench for rv32_id_ex_stage: behavioural model checked every cycle plus literal expectations.
module tb_rv32_id_ex_stage;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, id_valid = 1'b0, ex_ready = 1'b1;
  logic        id_ready;
  logic [31:0] id_instr = '0, id_pc = '0, id_rs1_data = '0, id_rs2_data = '0;
  logic        exm_wr_en = 1'b0, mwb_wr_en = 1'b0;
  logic [4:0]  exm_rd = '0, mwb_rd = '0;
  logic [31:0] exm_data = '0, mwb_data = '0;
  logic        ex_valid, ex_wr_en, ex_is_load;
  logic        ex_shift_en, ex_shift_logical, ex_shift_direction, ex_shift_immediate;
  logic [31:0] ex_code_bus, ex_pc, ex_rs1, ex_rs2;
  logic [4:0]  ex_rd;

  rv32_id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_code_bus(ex_code_bus), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_shift_en(ex_shift_en), .ex_shift_logical(ex_shift_logical),
    .ex_shift_direction(ex_shift_direction), .ex_shift_immediate(ex_shift_immediate)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model of what the EX slot must contain.
  bit          m_live = 1'b0;
  bit          m_valid, m_wr, m_ld, m_sen, m_slog, m_sdir, m_simm;
  logic [31:0] m_instr, m_pc, m_rs1, m_rs2;
  logic [4:0]  m_rd;

  function automatic bit reads_rs1(input logic [6:0] op);
    return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return (op == 7'h33 || op == 7'h23 || op == 7'h63);
  endfunction

  function automatic bit m_stall();
    logic [6:0] op = id_instr[6:0];
    if (!(m_valid && m_ld && m_wr) || m_rd == 5'd0) return 1'b0;
    return (reads_rs1(op) && m_rd == id_instr[19:15]) || (reads_rs2(op) && m_rd == id_instr[24:20]);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return rf;
    if (exm_wr_en && exm_rd == rs) return exm_data;
    if (mwb_wr_en && mwb_rd == rs) return mwb_data;
    return rf;
  endfunction

  task automatic m_clear();
    {m_valid, m_wr, m_ld, m_sen, m_slog, m_sdir, m_simm} = '0;
    m_instr = '0; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
  endtask

  task automatic m_load();
    logic [6:0] op = id_instr[6:0];
    logic [2:0] fn = id_instr[14:12];
    bit is_shift;
    m_valid = 1'b1; m_instr = id_instr; m_pc = id_pc; m_rd = id_instr[11:7];
    m_rs1 = operand(id_instr[19:15], id_rs1_data);
    m_rs2 = operand(id_instr[24:20], id_rs2_data);
    m_ld  = (op == 7'h03);
    m_wr  = (m_rd != 0) && (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h37 ||
                            op == 7'h17 || op == 7'h6F || op == 7'h67);
    case (op)
      7'h33:   is_shift = (fn == 3'd1 || fn == 3'd5);
      7'h13:   is_shift = (fn == 3'd5) || (fn == 3'd1 && id_instr[31:25] == 7'd0);
      default: is_shift = 1'b0;
    endcase
    m_sen  = is_shift;
    m_sdir = is_shift && fn == 3'd5;
    m_slog = is_shift && !id_instr[30];
    m_simm = is_shift && op == 7'h13;
  endtask

  always @(posedge clk) begin
    bit stall;
    stall = m_stall();
    if (rst) begin m_clear(); m_live = 1'b1; end
    else if (flush) m_clear();
    else if (ex_ready) begin
      if (id_valid && !stall) m_load();
      else m_clear();
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
      chk("m_id_ready", {31'd0, id_ready}, {31'd0, ex_ready && !flush && !m_stall()});
      chk("m_code_bus", ex_code_bus, m_instr);
      chk("m_pc", ex_pc, m_pc);
      chk("m_rs1", ex_rs1, m_rs1);
      chk("m_rs2", ex_rs2, m_rs2);
      chk("m_rd", {27'd0, ex_rd}, {27'd0, m_rd});
      chk("m_ctl", {25'd0, ex_wr_en, ex_is_load, ex_shift_en, ex_shift_logical, ex_shift_direction,
                    ex_shift_immediate, 1'b0},
                   {25'd0, m_wr, m_ld, m_sen, m_slog, m_sdir, m_simm, 1'b0});
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic settle(); #1; endtask

  initial begin
    logic [31:0] held;
    // Reset with junk on the ID inputs
    rst = 1'b1; id_valid = 1'b1; id_instr = 32'h0000A383; id_rs1_data = 32'hFFFF_FFFF;
    tick(); tick();
    rst = 1'b0; id_valid = 1'b0;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_bus", ex_code_bus, 32'd0);
    chk("rst_rs1", ex_rs1, 32'd0);
    chk("rst_wr_en", {31'd0, ex_wr_en}, 32'd0);
    settle();
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);

    // srai x1,x1,3
    id_valid = 1'b1; id_instr = 32'h4030D093; id_pc = 32'h100;
    id_rs1_data = 32'h8000_0000; id_rs2_data = 32'h1;
    tick();
    chk("srai_valid", {31'd0, ex_valid}, 32'd1);
    chk("srai_shift", {28'd0, ex_shift_en, ex_shift_direction, ex_shift_logical, ex_shift_immediate}, 32'b1101);
    chk("srai_rs1", ex_rs1, 32'h8000_0000);
    chk("srai_rd", {27'd0, ex_rd}, 32'd1);

    // add x3,x5,x0 with both forwarding sources matching x5
    id_instr = 32'h000281B3; id_rs1_data = 32'h1234_5678;
    exm_wr_en = 1'b1; exm_rd = 5'd5; exm_data = 32'hAAAA_AAAA;
    mwb_wr_en = 1'b1; mwb_rd = 5'd5; mwb_data = 32'h5555_5555;
    tick();
    chk("fwd_exm_wins", ex_rs1, 32'hAAAA_AAAA);
    exm_wr_en = 1'b0;
    tick();
    chk("fwd_mwb", ex_rs1, 32'h5555_5555);
    // add x3,x0,x0 with writebacks aimed at x0
    id_instr = 32'h000001B3; exm_wr_en = 1'b1; exm_rd = 5'd0; mwb_rd = 5'd0;
    tick();
    chk("fwd_x0", ex_rs1, 32'h1234_5678);

    // add x3,x1,x2: no shift controls
    exm_wr_en = 1'b0; mwb_wr_en = 1'b0; id_instr = 32'h002081B3;
    tick();
    chk("add_shift", {28'd0, ex_shift_en, ex_shift_direction, ex_shift_logical, ex_shift_immediate}, 32'd0);
    chk("add_rd_wr", {26'd0, ex_wr_en, ex_rd}, {26'd0, 1'b1, 5'd3});

    // lw x7,0(x1) then sll x8,x7,x2
    id_instr = 32'h0000A383;
    tick();
    chk("lw_ctl", {25'd0, ex_is_load, ex_wr_en, ex_rd}, {25'd0, 1'b1, 1'b1, 5'd7});
    id_instr = 32'h00239433; id_rs1_data = 32'h1111_1111; id_rs2_data = 32'd4;
    settle();
    chk("lu_stall_ready", {31'd0, id_ready}, 32'd0);
    tick();
    chk("lu_bubble", {30'd0, ex_valid, ex_wr_en}, 32'd0);
    mwb_wr_en = 1'b1; mwb_rd = 5'd7; mwb_data = 32'hDEAD_BEEF;
    settle();
    chk("lu_release_ready", {31'd0, id_ready}, 32'd1);
    tick();
    chk("lu_sll_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_sll_rs1", ex_rs1, 32'hDEAD_BEEF);
    chk("lu_sll_shift", {28'd0, ex_shift_en, ex_shift_direction, ex_shift_logical, ex_shift_immediate}, 32'b1010);
    mwb_wr_en = 1'b0;

    // Backpressure: addi x9,x0,5 waiting
    held = ex_code_bus;
    id_instr = 32'h00500493; ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_ready", {31'd0, id_ready}, 32'd0);
      tick();
      chk("bp_hold", ex_code_bus, 32'h00239433);
      chk("bp_hold_cmp", ex_code_bus, held);
    end
    ex_ready = 1'b1;
    settle();
    chk("bp_release_ready", {31'd0, id_ready}, 32'd1);
    tick();
    chk("bp_accept", ex_code_bus, 32'h00500493);

    // Flush during a load-use stall
    id_instr = 32'h0000A383;
    tick();
    id_instr = 32'h00239433; flush = 1'b1;
    settle();
    chk("fl_ready", {31'd0, id_ready}, 32'd0);
    tick();
    chk("fl_bubble", {30'd0, ex_valid, ex_wr_en}, 32'd0);
    chk("fl_not_taken", ex_code_bus, 32'd0);
    flush = 1'b0;
    tick();
    chk("fl_after", ex_code_bus, 32'h00239433);
    // Flush beats backpressure
    ex_ready = 1'b0; flush = 1'b1;
    tick();
    chk("fl_over_bp", {30'd0, ex_valid, ex_wr_en}, 32'd0);
    ex_ready = 1'b1; flush = 1'b0;

    // Malformed slli x1,x1 with funct7=0100000
    id_instr = 32'h40009093;
    tick();
    chk("bad_slli", {29'd0, ex_valid, ex_wr_en, ex_shift_en}, 32'b110);

    // Reset mid-operation
    id_instr = 32'h00500493;
    tick();
    chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst", {31'd0, ex_valid} | ex_pc | ex_rs1 | ex_code_bus, 32'd0);
    rst = 1'b0; id_valid = 1'b0;
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
